i2c_mem_target: RTL and testbench
=================================

# i2c_mem_target

I2C target-side memory block: the downstream consumer of the bus master's SCL/SDA outputs in the I2C memory subsystem. Oversamples SCL/SDA on the system clock, detects START/STOP, decodes the 7-bit device address and R/W bit, and services byte writes and sequential reads against an internal byte array through an auto-incrementing word pointer. SDA is driven open-drain through an output-enable.

## Interface
Parameters:
- DEV_ADDR, 7'h50, 7-bit device address this target responds to
- MEM_DEPTH, 256, number of bytes in the array; the word pointer is 8 bits and wraps modulo MEM_DEPTH

Ports:
- clk  input  1  system clock; every register updates on posedge clk
- Reset  input  1  synchronous, active-low reset; sampled on posedge clk
- SCL  input  1  bus clock from the master
- SDA_in  input  1  bus data as seen on the wire
- SDA_oe  output  1  1 = pull SDA low; 0 = release
- busy  output  1  1 from a detected START until STOP, address mismatch, or NACK
- wr_strobe  output  1  one-clk pulse per committed write byte
- wr_addr  output  8  array address of the committed byte; valid with wr_strobe
- wr_data  output  8  committed byte; valid with wr_strobe

## Operation
- SCL and SDA_in each pass through a 2-flop synchronizer, then a 1-flop delay for edge detection (sSCL, sSDA).
- START: sSDA falls while sSCL = 1. STOP: sSDA rises while sSCL = 1. Both are honoured in every state, including mid-byte.
- Bits are sampled on sSCL rising edges, MSB first. SDA_oe changes only on sSCL falling edges.
- States:
  - IDLE: SDA_oe = 0, busy = 0. START -> DEV.
  - DEV: shift 8 bits. Then:
    - addr[7:1] == DEV_ADDR and R/W = 0 -> ACK_DEV, with a write to follow.
    - match and R/W = 1 -> ACK_DEV, with a read to follow.
    - mismatch -> IGNORE.
  - ACK_DEV: drive ACK. On the falling edge that ends the ACK bit, go to WORD (write) or RD_DATA (read).
  - WORD: shift 8 bits into the pointer -> ACK_WORD -> WR_DATA.
  - WR_DATA: shift 8 bits. On the 8th rising edge: mem[ptr] <= byte, wr_strobe = 1, wr_addr = ptr, wr_data = byte, ptr++. Then -> ACK_WR -> WR_DATA.
  - RD_DATA: at entry, load shift register from mem[ptr] and ptr++. Drive SDA_oe = ~bit for 8 bits, then release -> RD_ACK.
  - RD_ACK: sample the master's bit on the 9th rising edge. 0 (ACK) -> RD_DATA; 1 (NACK) -> IGNORE.
  - IGNORE: SDA_oe = 0, busy = 0. Wait for START (-> DEV) or STOP (-> IDLE).
- START in any state -> DEV. The bit counter clears and the pointer is kept, so a repeated start gives a random read.
- STOP in any state -> IDLE. A partial byte is discarded and no write occurs.
- Pointer wraps from MEM_DEPTH-1 to 0 on both read and write.
- ACK = SDA_oe held at 1 for exactly one SCL bit period (the 9th bit).
- Reset (Reset = 0 on a posedge):
  - state = IDLE, SDA_oe = 0, busy = 0, wr_strobe = 0, wr_addr = 0, wr_data = 0, ptr = 0, bit counter = 0.
  - Array contents are not cleared.
  - Reset mid-transfer aborts immediately. The target stays in IDLE until the next START, even if the bus is mid-byte.

## Timing
- Pin-to-event latency: 3 clk from a pin change to the internal edge or START/STOP decision.
- SCL high and low phases must each be ≥ 4 clk. SDA must be stable ≥ 4 clk around SCL rising edges.
- wr_strobe is asserted in the clk cycle after the 8th data-bit rising edge is detected, for exactly 1 clk. The array write occurs on that same posedge.
- SDA_oe assert/release happens 1 clk after the falling-edge detection: 4 clk after the SCL pin falls.
- Read-data byte load (array read) occurs in the same clk as the falling edge ending the preceding ACK. The first bit is on SDA_oe in the next clk.
- busy rises 1 clk after START detection and falls 1 clk after STOP, mismatch, or NACK detection.
- START and STOP are never detected in the same clk. If an SCL edge and an SDA edge are detected in the same clk, the SCL edge is processed and SDA is re-evaluated next clk.

## Test plan
- Reset: hold Reset = 0 for 2 clk during an active read -> next clk SDA_oe = 0, busy = 0, wr_strobe = 0. A following read of 0xA1 returns the byte at address 0x00.
- Write: S, 0xA0, 0x10, 0x55, 0xAA, P ->
  - SDA_oe = 1 in all four 9th-bit slots.
  - wr_strobe pulses twice: (0x10, 0x55), then (0x11, 0xAA).
  - busy = 0 after P.
- Random read: S, 0xA0, 0x10, Sr, 0xA1, read byte with master ACK, read byte with master NACK, P -> bus data 0x55 then 0xAA. SDA_oe = 0 after the NACK; no wr_strobe.
- Address mismatch: S, 0xA2, 0x10, 0x77, P -> SDA_oe stays 0 throughout, no wr_strobe, busy = 0 from the 8th bit onward.
- Wrap: S, 0xA0, 0xFF, 0x11, 0x22, P -> writes (0xFF, 0x11) then (0x00, 0x22). A read from 0xFF returns 0x11, 0x22.
- Abort: S, 0xA0, 0x20, 4 data bits, P -> no wr_strobe, busy = 0, mem[0x20] unchanged. An immediately following full write to 0x20 succeeds.

Source files
------------

// File: rtl/i2c_mem_target.sv
// i2c_mem_target
//   I2C target backed by a byte array. SCL/SDA are oversampled on clk,
//   START/STOP are decoded, and the target services byte writes and
//   sequential reads through an auto-incrementing word pointer. SDA is
//   driven open-drain through SDA_oe.
// Ports
//   clk        system clock
//   Reset      synchronous active-low reset
//   SCL        bus clock from the master
//   SDA_in     bus data as seen on the wire
//   SDA_oe     1 = pull SDA low, 0 = release
//   busy       high from START until STOP, address mismatch or NACK
//   wr_strobe  one-clk pulse per committed write byte
//   wr_addr    array address of the committed byte
//   wr_data    committed byte
module i2c_mem_target #(
  parameter logic [6:0] DEV_ADDR  = 7'h50,
  parameter int         MEM_DEPTH = 256
) (
  input  logic       clk,
  input  logic       Reset,
  input  logic       SCL,
  input  logic       SDA_in,
  output logic       SDA_oe,
  output logic       busy,
  output logic       wr_strobe,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data
);

  typedef enum logic [3:0] {
    IDLE, DEV, ACK_DEV, WORD, ACK_WORD, WR_DATA, ACK_WR, RD_DATA, RD_ACK, IGNORE
  } state_t;

  state_t     state;
  logic [3:0] cnt;
  logic [7:0] sh;
  logic [7:0] ptr;
  logic       rd;
  logic [7:0] mem [MEM_DEPTH];

  // Synchronizers are deliberately not reset: after a mid-transfer reset
  // they must keep tracking the real bus so that a low SDA line is not
  // mistaken for a fresh START.
  logic scl_s1, scl_s2, scl_d;
  logic sda_s1, sda_s2, sda_d;
  logic scl_rise, scl_fall, scl_edge;
  logic start_det, stop_det;

  assign scl_rise = scl_s2 & ~scl_d;
  assign scl_fall = ~scl_s2 & scl_d;
  assign scl_edge = scl_rise | scl_fall;

  // sda_d is held while an SCL edge is processed, so a coincident SDA edge
  // is still visible (and re-evaluated) on the following clk.
  always_ff @(posedge clk) begin
    scl_s1 <= SCL;
    scl_s2 <= scl_s1;
    scl_d  <= scl_s2;
    sda_s1 <= SDA_in;
    sda_s2 <= sda_s1;
    if (!scl_edge) sda_d <= sda_s2;
  end

  assign start_det = ~scl_edge & scl_s2 &  sda_d & ~sda_s2;
  assign stop_det  = ~scl_edge & scl_s2 & ~sda_d &  sda_s2;

  logic [7:0] byte_in;
  logic [7:0] ptr_inc;
  logic [7:0] rd_byte;
  logic       wr_fire;

  assign byte_in = {sh[6:0], sda_s2};
  assign ptr_inc = (ptr == 8'(MEM_DEPTH - 1)) ? 8'd0 : ptr + 8'd1;
  assign rd_byte = mem[ptr];
  assign wr_fire = Reset && !start_det && !stop_det && (state == WR_DATA)
                   && scl_rise && (cnt == 4'd7);

  // Array is never cleared by reset.
  always_ff @(posedge clk) begin
    if (wr_fire) mem[ptr] <= byte_in;
  end

  always_ff @(posedge clk) begin
    if (!Reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      sh        <= 8'd0;
      ptr       <= 8'd0;
      rd        <= 1'b0;
      SDA_oe    <= 1'b0;
      busy      <= 1'b0;
      wr_strobe <= 1'b0;
      wr_addr   <= 8'd0;
      wr_data   <= 8'd0;
    end else begin
      wr_strobe <= 1'b0;
      if (start_det) begin
        // pointer kept: repeated start gives a random read
        state  <= DEV;
        cnt    <= 4'd0;
        busy   <= 1'b1;
        SDA_oe <= 1'b0;
      end else if (stop_det) begin
        state  <= IDLE;
        cnt    <= 4'd0;
        busy   <= 1'b0;
        SDA_oe <= 1'b0;
      end else begin
        case (state)
          DEV, WORD, WR_DATA: begin
            if (scl_rise) begin
              sh  <= byte_in;
              cnt <= cnt + 4'd1;
              if (cnt == 4'd7) begin
                cnt <= 4'd0;
                case (state)
                  DEV: begin
                    if (byte_in[7:1] == DEV_ADDR) begin
                      state <= ACK_DEV;
                      rd    <= byte_in[0];
                    end else begin
                      state <= IGNORE;
                      busy  <= 1'b0;
                    end
                  end
                  WORD: begin
                    ptr   <= byte_in;
                    state <= ACK_WORD;
                  end
                  default: begin
                    wr_strobe <= 1'b1;
                    wr_addr   <= ptr;
                    wr_data   <= byte_in;
                    ptr       <= ptr_inc;
                    state     <= ACK_WR;
                  end
                endcase
              end
            end
          end
          // First falling edge starts the ACK bit, the second one ends it.
          ACK_DEV, ACK_WORD, ACK_WR: begin
            if (scl_fall) begin
              if (!SDA_oe) begin
                SDA_oe <= 1'b1;
              end else if (state == ACK_DEV && rd) begin
                sh     <= rd_byte;
                SDA_oe <= ~rd_byte[7];
                ptr    <= ptr_inc;
                cnt    <= 4'd0;
                state  <= RD_DATA;
              end else begin
                SDA_oe <= 1'b0;
                state  <= (state == ACK_DEV) ? WORD : WR_DATA;
              end
            end
          end
          // Bit 7 is already on the wire at entry; each falling edge
          // presents the next bit, the one after the 8th releases SDA.
          RD_DATA: begin
            if (scl_rise) begin
              cnt <= cnt + 4'd1;
            end else if (scl_fall && cnt != 4'd0) begin
              if (cnt == 4'd8) begin
                SDA_oe <= 1'b0;
                cnt    <= 4'd0;
                state  <= RD_ACK;
              end else begin
                SDA_oe <= ~sh[6];
                sh     <= {sh[6:0], 1'b0};
              end
            end
          end
          // cnt = 1 marks a master ACK waiting for the falling edge that
          // ends the ACK bit, where the next byte is loaded.
          RD_ACK: begin
            if (scl_rise) begin
              if (sda_s2) begin
                state <= IGNORE;
                busy  <= 1'b0;
              end else begin
                cnt <= 4'd1;
              end
            end else if (scl_fall && cnt == 4'd1) begin
              sh     <= rd_byte;
              SDA_oe <= ~rd_byte[7];
              ptr    <= ptr_inc;
              cnt    <= 4'd0;
              state  <= RD_DATA;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_mem_target.sv
module tb_i2c_mem_target;

  logic       clk = 1'b0;
  logic       Reset = 1'b0;
  logic       SCL = 1'b1;
  logic       sda_m = 1'b1;
  logic       SDA_in;
  logic       SDA_oe, busy, wr_strobe;
  logic [7:0] wr_addr, wr_data;

  int checks = 0;
  int errors = 0;

  // open-drain wire
  assign SDA_in = sda_m & ~SDA_oe;

  always #5 clk = ~clk;

  i2c_mem_target #(.DEV_ADDR(7'h50), .MEM_DEPTH(256)) dut (
    .clk(clk), .Reset(Reset), .SCL(SCL), .SDA_in(SDA_in), .SDA_oe(SDA_oe),
    .busy(busy), .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  // bus monitor: free-running counters and a log of committed writes
  int          oe_cnt = 0;
  int          busy_cnt = 0;
  logic [15:0] wlog[$];
  always @(negedge clk) begin
    if (SDA_oe) oe_cnt++;
    if (busy) busy_cnt++;
    if (wr_strobe) wlog.push_back({wr_addr, wr_data});
  end

  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start;
    wclk(4); sda_m = 1'b1; wclk(4); SCL = 1'b1; wclk(8); sda_m = 1'b0; wclk(8); SCL = 1'b0;
  endtask

  task automatic i2c_stop;
    wclk(4); sda_m = 1'b0; wclk(4); SCL = 1'b1; wclk(8); sda_m = 1'b1; wclk(8);
  endtask

  task automatic wbit(input logic b);
    wclk(4); sda_m = b; wclk(4); SCL = 1'b1; wclk(8); SCL = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) wbit(b[i]);
    wclk(4); sda_m = 1'b1; wclk(4); SCL = 1'b1; wclk(4); ack = SDA_oe; wclk(4); SCL = 1'b0;
  endtask

  task automatic rbit(output logic b);
    wclk(4); sda_m = 1'b1; wclk(4); SCL = 1'b1; wclk(4); b = SDA_in; wclk(4); SCL = 1'b0;
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] d);
    logic b;
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      rbit(b);
      d = {d[6:0], b};
    end
    wclk(4); sda_m = ~mack; wclk(4); SCL = 1'b1; wclk(8); SCL = 1'b0;
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] d);
    logic ack;
    i2c_start; send_byte(8'hA0, ack); send_byte(a, ack); send_byte(d, ack); i2c_stop;
  endtask

  task automatic do_read1(input logic [7:0] a, output logic [7:0] d);
    logic ack;
    i2c_start; send_byte(8'hA0, ack); send_byte(a, ack);
    i2c_start; send_byte(8'hA1, ack); read_byte(1'b0, d); i2c_stop;
  endtask

  task automatic test_reset;
    Reset = 1'b0; SCL = 1'b1; sda_m = 1'b1;
    wclk(6);
    checks++; if (SDA_oe !== 1'b0) begin errors++; $display("FAIL rst_oe: got %b want 0", SDA_oe); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if (wr_strobe !== 1'b0) begin errors++; $display("FAIL rst_strobe: got %b want 0", wr_strobe); end
    checks++; if (wr_addr !== 8'h00) begin errors++; $display("FAIL rst_addr: got %h want 00", wr_addr); end
    checks++; if (wr_data !== 8'h00) begin errors++; $display("FAIL rst_data: got %h want 00", wr_data); end
    Reset = 1'b1;
    wclk(4);
  endtask

  task automatic test_write;
    logic [7:0] bytes [4];
    logic       ack;
    int         base;
    bytes[0] = 8'hA0; bytes[1] = 8'h10; bytes[2] = 8'h55; bytes[3] = 8'hAA;
    base = wlog.size();
    i2c_start;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL wr_busy_start: got %b want 1", busy); end
    for (int i = 0; i < 4; i++) begin
      send_byte(bytes[i], ack);
      checks++; if (ack !== 1'b1) begin errors++; $display("FAIL wr_ack%0d: got %b want 1", i, ack); end
    end
    i2c_stop;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wr_busy_stop: got %b want 0", busy); end
    checks++; if (wlog.size() - base !== 2) begin errors++; $display("FAIL wr_count: got %0d want 2", wlog.size() - base); end
    checks++; if (((wlog.size() > base) ? wlog[base] : 16'hxxxx) !== 16'h1055) begin
      errors++; $display("FAIL wr_first: got %h want 1055", (wlog.size() > base) ? wlog[base] : 16'hxxxx); end
    checks++; if (((wlog.size() > base + 1) ? wlog[base+1] : 16'hxxxx) !== 16'h11AA) begin
      errors++; $display("FAIL wr_second: got %h want 11aa", (wlog.size() > base + 1) ? wlog[base+1] : 16'hxxxx); end
  endtask

  task automatic test_random_read;
    logic       ack;
    logic [7:0] d0, d1;
    int         base;
    base = wlog.size();
    i2c_start; send_byte(8'hA0, ack); send_byte(8'h10, ack);
    i2c_start; send_byte(8'hA1, ack);
    read_byte(1'b1, d0);
    read_byte(1'b0, d1);
    wclk(2);
    checks++; if (SDA_oe !== 1'b0) begin errors++; $display("FAIL rr_oe_nack: got %b want 0", SDA_oe); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rr_busy_nack: got %b want 0", busy); end
    i2c_stop;
    checks++; if (d0 !== 8'h55) begin errors++; $display("FAIL rr_byte0: got %h want 55", d0); end
    checks++; if (d1 !== 8'hAA) begin errors++; $display("FAIL rr_byte1: got %h want aa", d1); end
    checks++; if (wlog.size() != base) begin errors++; $display("FAIL rr_no_write: got %0d want 0", wlog.size() - base); end
  endtask

  task automatic test_mismatch;
    logic ack;
    int   base, oe0, b0;
    base = wlog.size();
    oe0  = oe_cnt;
    i2c_start;
    send_byte(8'hA2, ack);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL mm_ack: got %b want 0", ack); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mm_busy: got %b want 0", busy); end
    b0 = busy_cnt;
    send_byte(8'h10, ack); send_byte(8'h77, ack);
    i2c_stop;
    checks++; if (oe_cnt != oe0) begin errors++; $display("FAIL mm_oe: got %0d cycles want 0", oe_cnt - oe0); end
    checks++; if (busy_cnt != b0) begin errors++; $display("FAIL mm_busy_after: got %0d cycles want 0", busy_cnt - b0); end
    checks++; if (wlog.size() != base) begin errors++; $display("FAIL mm_no_write: got %0d want 0", wlog.size() - base); end
  endtask

  task automatic test_wrap;
    logic       ack;
    logic [7:0] d0, d1;
    int         base;
    base = wlog.size();
    i2c_start; send_byte(8'hA0, ack); send_byte(8'hFF, ack);
    send_byte(8'h11, ack); send_byte(8'h22, ack); i2c_stop;
    checks++; if (((wlog.size() > base) ? wlog[base] : 16'hxxxx) !== 16'hFF11) begin
      errors++; $display("FAIL wrap_w0: got %h want ff11", (wlog.size() > base) ? wlog[base] : 16'hxxxx); end
    checks++; if (((wlog.size() > base + 1) ? wlog[base+1] : 16'hxxxx) !== 16'h0022) begin
      errors++; $display("FAIL wrap_w1: got %h want 0022", (wlog.size() > base + 1) ? wlog[base+1] : 16'hxxxx); end
    i2c_start; send_byte(8'hA0, ack); send_byte(8'hFF, ack);
    i2c_start; send_byte(8'hA1, ack);
    read_byte(1'b1, d0); read_byte(1'b0, d1); i2c_stop;
    checks++; if (d0 !== 8'h11) begin errors++; $display("FAIL wrap_r0: got %h want 11", d0); end
    checks++; if (d1 !== 8'h22) begin errors++; $display("FAIL wrap_r1: got %h want 22", d1); end
  endtask

  task automatic test_abort;
    logic       ack;
    logic [7:0] d;
    int         base;
    do_write(8'h20, 8'h5A);
    base = wlog.size();
    i2c_start; send_byte(8'hA0, ack); send_byte(8'h20, ack);
    wbit(1'b1); wbit(1'b0); wbit(1'b0); wbit(1'b1);
    i2c_stop;
    checks++; if (wlog.size() != base) begin errors++; $display("FAIL ab_no_write: got %0d want 0", wlog.size() - base); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ab_busy: got %b want 0", busy); end
    do_read1(8'h20, d);
    checks++; if (d !== 8'h5A) begin errors++; $display("FAIL ab_mem_kept: got %h want 5a", d); end
    base = wlog.size();
    do_write(8'h20, 8'hC3);
    checks++; if (((wlog.size() > base) ? wlog[base] : 16'hxxxx) !== 16'h20C3) begin
      errors++; $display("FAIL ab_rewrite: got %h want 20c3", (wlog.size() > base) ? wlog[base] : 16'hxxxx); end
    do_read1(8'h20, d);
    checks++; if (d !== 8'hC3) begin errors++; $display("FAIL ab_readback: got %h want c3", d); end
  endtask

  task automatic test_reset_mid_read;
    logic       ack, b;
    logic [7:0] d;
    i2c_start; send_byte(8'hA1, ack);
    rbit(b); rbit(b); rbit(b);
    Reset = 1'b0;
    wclk(2);
    checks++; if (SDA_oe !== 1'b0) begin errors++; $display("FAIL mr_oe: got %b want 0", SDA_oe); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mr_busy: got %b want 0", busy); end
    checks++; if (wr_strobe !== 1'b0) begin errors++; $display("FAIL mr_strobe: got %b want 0", wr_strobe); end
    Reset = 1'b1;
    i2c_start; send_byte(8'hA1, ack);
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL mr_ack: got %b want 1", ack); end
    read_byte(1'b0, d);
    i2c_stop;
    // pointer was reset to 0; mem[0] holds 0x22 from the wrap write
    checks++; if (d !== 8'h22) begin errors++; $display("FAIL mr_read0: got %h want 22", d); end
  endtask

  initial begin
    test_reset;
    test_write;
    test_random_read;
    test_mismatch;
    test_wrap;
    test_abort;
    test_reset_mid_read;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
